// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffered UART transmitter with per-frame
// parity/stop selection and back-to-back frame streaming.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Idle,
  output logic [CW-1:0]        o_Fifo_Count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] C_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] C_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] B_LAST = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_Mem [FIFO_DEPTH];
  logic [PW-1:0]        r_Wr_Ptr;
  logic [PW-1:0]        r_Rd_Ptr;
  logic [CW-1:0]        r_Count;
  logic                 r_Ready;

  state_t               r_State;
  logic [TW-1:0]        r_Clk_Cnt;
  logic [IW-1:0]        r_Bit_Idx;
  logic [DATA_BITS-1:0] r_Data;
  logic                 r_Par;
  logic                 r_Par_En;
  logic                 r_Two_Left;
  logic                 r_Serial;
  logic                 r_Active;
  logic                 r_Done;
  logic                 r_Idle;

  logic                 w_Push;
  logic                 w_Pop;
  logic                 w_Not_Empty;
  logic                 w_Frame_End;
  logic                 w_Go_Idle;
  logic [CW-1:0]        w_Count_Nxt;
  logic [DATA_BITS-1:0] w_Pop_Word;
  logic                 w_Par_Even;
  logic                 w_Par_Bit;
  logic                 w_Par_En;

  assign w_Push      = i_Tx_DV && r_Ready;
  assign w_Not_Empty = (r_Count != '0);
  assign w_Frame_End = (r_State == S_STOP) &&
                       (r_Clk_Cnt == C_LAST) &&
                       !r_Two_Left;
  assign w_Pop       = w_Not_Empty &&
                       ((r_State == S_IDLE) || w_Frame_End);
  assign w_Go_Idle   = !w_Not_Empty &&
                       ((r_State == S_IDLE) || w_Frame_End);
  assign w_Pop_Word  = r_Mem[r_Rd_Ptr];
  assign w_Par_Even  = ^w_Pop_Word;
  assign w_Par_Bit   = (i_Parity_Mode == 2'b10) ?
                       ~w_Par_Even : w_Par_Even;
  assign w_Par_En    = (i_Parity_Mode == 2'b01) ||
                       (i_Parity_Mode == 2'b10);

  // Next FIFO occupancy; push and pop together cancel out.
  always_comb begin
    w_Count_Nxt = r_Count;
    case ({w_Push, w_Pop})
      2'b10:   w_Count_Nxt = r_Count + CW'(1);
      2'b01:   w_Count_Nxt = r_Count - CW'(1);
      default: w_Count_Nxt = r_Count;
    endcase
  end

  // FIFO storage; contents need no reset since the count gates reads.
  always_ff @(posedge i_Clock) begin
    if (w_Push) begin
      r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
    end
  end

  // FIFO pointers, occupancy and registered not-full flag.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
      r_Ready  <= 1'b1;
    end else begin
      if (w_Push) begin
        r_Wr_Ptr <= r_Wr_Ptr + PW'(1);
      end
      if (w_Pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + PW'(1);
      end
      r_Count <= w_Count_Nxt;
      r_Ready <= (w_Count_Nxt != C_FULL);
    end
  end

  // Frame serialiser; a pop at frame end chains straight into START.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State    <= S_IDLE;
      r_Clk_Cnt  <= '0;
      r_Bit_Idx  <= '0;
      r_Data     <= '0;
      r_Par      <= 1'b0;
      r_Par_En   <= 1'b0;
      r_Two_Left <= 1'b0;
      r_Serial   <= 1'b1;
      r_Active   <= 1'b0;
      r_Done     <= 1'b0;
      r_Idle     <= 1'b1;
    end else begin
      r_Done <= 1'b0;
      r_Idle <= w_Go_Idle && !w_Push;
      case (r_State)
        S_IDLE: begin
          r_Serial <= 1'b1;
          r_Active <= 1'b0;
        end
        S_START: begin
          if (r_Clk_Cnt == C_LAST) begin
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
            r_Serial  <= r_Data[0];
            r_State   <= S_DATA;
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        S_DATA: begin
          if (r_Clk_Cnt == C_LAST) begin
            r_Clk_Cnt <= '0;
            if (r_Bit_Idx == B_LAST) begin
              if (r_Par_En) begin
                r_Serial <= r_Par;
                r_State  <= S_PARITY;
              end else begin
                r_Serial <= 1'b1;
                r_State  <= S_STOP;
              end
            end else begin
              r_Bit_Idx <= r_Bit_Idx + IW'(1);
              r_Data    <= r_Data >> 1;
              r_Serial  <= r_Data[1];
            end
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        S_PARITY: begin
          if (r_Clk_Cnt == C_LAST) begin
            r_Clk_Cnt <= '0;
            r_Serial  <= 1'b1;
            r_State   <= S_STOP;
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        S_STOP: begin
          if ((r_Clk_Cnt == C_PRE) && !r_Two_Left) begin
            r_Done <= 1'b1;
          end
          if (r_Clk_Cnt == C_LAST) begin
            r_Clk_Cnt <= '0;
            if (r_Two_Left) begin
              r_Two_Left <= 1'b0;
            end else begin
              r_State  <= S_IDLE;
              r_Active <= 1'b0;
            end
          end else begin
            r_Clk_Cnt <= r_Clk_Cnt + TW'(1);
          end
        end
        default: begin
          r_State  <= S_IDLE;
          r_Serial <= 1'b1;
          r_Active <= 1'b0;
        end
      endcase
      if (w_Pop) begin
        r_State    <= S_START;
        r_Clk_Cnt  <= '0;
        r_Data     <= w_Pop_Word;
        r_Par      <= w_Par_Bit;
        r_Par_En   <= w_Par_En;
        r_Two_Left <= i_Two_Stop;
        r_Serial   <= 1'b0;
        r_Active   <= 1'b1;
      end
    end
  end

  assign o_Tx_Ready   = r_Ready;
  assign o_Tx_Serial  = r_Serial;
  assign o_Tx_Active  = r_Active;
  assign o_Tx_Done    = r_Done;
  assign o_Tx_Idle    = r_Idle;
  assign o_Fifo_Count = r_Count;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame with
// 8-bit and 9-bit instances at 4 clocks per bit.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct packed {
    logic [8:0] data;
    logic       pen;
    logic       par;
    logic       two;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       two;

  logic       dv8;
  logic [7:0] byte8;
  logic       rdy8, s8, a8, d8, i8;
  logic [2:0] cnt8;

  logic       dv9;
  logic [8:0] byte9;
  logic       rdy9, s9, a9, d9, i9;
  logic [2:0] cnt9;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  frame_t q8[$];
  frame_t q9[$];
  frame_t f8, f9;
  bit     in8 = 0, in9 = 0;
  int     c8, c9;
  int     nf8 = 0, nf9 = 0;
  int     b2b8 = 0;
  int     last8 = -10, last9 = -10;

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(4)
  ) u_dut8 (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Tx_DV(dv8), .i_Tx_Byte(byte8), .o_Tx_Ready(rdy8),
    .i_Parity_Mode(mode), .i_Two_Stop(two),
    .o_Tx_Serial(s8), .o_Tx_Active(a8), .o_Tx_Done(d8),
    .o_Tx_Idle(i8), .o_Fifo_Count(cnt8)
  );

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(9), .FIFO_DEPTH(4)
  ) u_dut9 (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Tx_DV(dv9), .i_Tx_Byte(byte9), .o_Tx_Ready(rdy9),
    .i_Parity_Mode(mode), .i_Two_Stop(two),
    .o_Tx_Serial(s9), .o_Tx_Active(a9), .o_Tx_Done(d9),
    .o_Tx_Idle(i9), .o_Fifo_Count(cnt9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(logic [8:0] d, logic [1:0] m,
                                logic t);
    frame_t f;
    f.data = d;
    f.pen  = (m == 2'b01) || (m == 2'b10);
    f.par  = (^d) ^ (m == 2'b10);
    f.two  = t;
    return f;
  endfunction

  function automatic int flen(frame_t f, int nb);
    return CPB * (1 + nb + int'(f.pen) + (f.two ? 2 : 1));
  endfunction

  function automatic logic ebit(frame_t f, int nb, int c);
    int b;
    logic [8:0] d;
    b = c / CPB;
    d = f.data;
    if (b == 0) return 1'b0;
    if (b <= nb) return d[b-1];
    if (f.pen && b == nb + 1) return f.par;
    return 1'b1;
  endfunction

  // Line monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      in8 = 0;
    end else begin
      if (!in8 && a8) begin
        check("frame8_expected", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          f8  = q8.pop_front();
          in8 = 1;
          c8  = 0;
          if (last8 == cyc - 1) b2b8++;
        end
      end
      if (in8) begin
        check("ser8", s8, ebit(f8, 8, c8));
        check("act8", a8, 1);
        check("done8", d8, c8 == flen(f8, 8) - 1);
        if (c8 == flen(f8, 8) - 1) begin
          in8 = 0;
          nf8++;
          last8 = cyc;
        end
        c8++;
      end else begin
        check("idle_ser8", s8, 1);
        check("idle_done8", d8, 0);
      end
    end
  end

  // Line monitor for the 9-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      in9 = 0;
    end else begin
      if (!in9 && a9) begin
        check("frame9_expected", q9.size() != 0, 1);
        if (q9.size() != 0) begin
          f9  = q9.pop_front();
          in9 = 1;
          c9  = 0;
        end
      end
      if (in9) begin
        check("ser9", s9, ebit(f9, 9, c9));
        check("done9", d9, c9 == flen(f9, 9) - 1);
        if (c9 == flen(f9, 9) - 1) begin
          in9 = 0;
          nf9++;
          last9 = cyc;
        end
        c9++;
      end else begin
        check("idle_ser9", s9, 1);
      end
    end
  end

  task automatic write8(logic [7:0] d);
    dv8   = 1'b1;
    byte8 = d;
    @(negedge clk);
    dv8 = 1'b0;
  endtask

  task automatic wait_frames8(int n, int budget);
    int k = 0;
    while (nf8 < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frames8", nf8, n);
  endtask

  task automatic wait_idle8(int budget);
    int k = 0;
    while (i8 !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle8", i8, 1);
    check("idle_act8", a8, 0);
    check("idle_cnt8", cnt8, 0);
  endtask

  initial begin
    int exp_cnt [10] = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4};
    int b0;
    rst_n = 1'b0;
    dv8   = 1'b0;
    byte8 = '0;
    dv9   = 1'b0;
    byte9 = '0;
    mode  = 2'b00;
    two   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ser", s8, 1);
    check("rst_rdy", rdy8, 1);
    check("rst_idle", i8, 1);
    check("rst_act", a8, 0);
    check("rst_done", d8, 0);
    check("rst_cnt", cnt8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, no parity, one stop; latency check
    q8.push_back(mk(9'h0A5, 2'b00, 1'b0));
    write8(8'hA5);
    check("lat_cnt1", cnt8, 1);
    check("lat_ser1", s8, 1);
    check("lat_act1", a8, 0);
    @(negedge clk);
    check("lat_ser0", s8, 0);
    check("lat_act", a8, 1);
    check("lat_cnt0", cnt8, 0);
    wait_frames8(1, 60);
    wait_idle8(10);

    // even then odd parity, two stop bits
    mode = 2'b01;
    two  = 1'b1;
    q8.push_back(mk(9'h0A5, 2'b01, 1'b1));
    write8(8'hA5);
    wait_frames8(2, 70);
    wait_idle8(10);
    mode = 2'b10;
    q8.push_back(mk(9'h0A5, 2'b10, 1'b1));
    write8(8'hA5);
    wait_frames8(3, 70);
    wait_idle8(10);

    // 9-bit word, odd parity, one stop
    mode  = 2'b10;
    two   = 1'b0;
    q9.push_back(mk(9'h1FF, 2'b10, 1'b0));
    dv9   = 1'b1;
    byte9 = 9'h1FF;
    @(negedge clk);
    dv9 = 1'b0;
    begin
      int k = 0;
      while (nf9 < 1 && k < 70) begin
        @(negedge clk);
        k++;
      end
    end
    check("frames9", nf9, 1);
    check("len9", last9 >= 0, 1);

    // burst: DV held 10 cycles, mode 11 means no parity
    mode = 2'b11;
    two  = 1'b0;
    b0   = b2b8;
    for (int k = 0; k < 10; k++) begin
      if (k < 5) q8.push_back(mk({1'b0, 8'(8'h10 + k)}, 2'b11, 1'b0));
      dv8   = 1'b1;
      byte8 = 8'(8'h10 + k);
      @(negedge clk);
      check("burst_cnt", cnt8, exp_cnt[k]);
      check("burst_rdy", rdy8, exp_cnt[k] != 4);
    end
    dv8 = 1'b0;
    wait_frames8(8, 260);
    check("burst_b2b", b2b8 - b0, 4);
    wait_idle8(10);

    // settings change mid-frame apply only to the next frame
    mode = 2'b00;
    two  = 1'b0;
    b0   = b2b8;
    q8.push_back(mk(9'h03A, 2'b00, 1'b0));
    q8.push_back(mk(9'h0C5, 2'b01, 1'b1));
    write8(8'h3A);
    write8(8'hC5);
    repeat (10) @(negedge clk);
    mode = 2'b01;
    two  = 1'b1;
    wait_frames8(10, 120);
    check("tog_b2b", b2b8 - b0, 1);
    wait_idle8(10);

    // reset in DATA with two words queued
    mode = 2'b00;
    two  = 1'b0;
    q8.push_back(mk(9'h03C, 2'b00, 1'b0));
    write8(8'h3C);
    write8(8'h11);
    write8(8'h22);
    check("pre_rst_cnt", cnt8, 2);
    repeat (12) @(negedge clk);
    check("pre_rst_act", a8, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ser", s8, 1);
    check("mid_rst_cnt", cnt8, 0);
    check("mid_rst_act", a8, 0);
    check("mid_rst_rdy", rdy8, 1);
    q8.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", i8, 1);
    check("post_rst_cnt", cnt8, 0);
    q8.push_back(mk(9'h055, 2'b00, 1'b0));
    write8(8'h55);
    wait_frames8(11, 60);
    wait_idle8(10);
    check("q8_empty", q8.size(), 0);
    check("q9_empty", q9.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
